axi4lite_mem_arbiter: RTL and testbench

Two-requester memory scheduler for the RV64IMAC core. It takes single-beat load/store requests from the instruction-fetch port (requester 0) and the data port (requester 1) and serialises them onto one AXI4-Lite master port. Only one transaction is outstanding at a time. Arbitration is round-robin by default, and each completed transaction returns a one-cycle response pulse to the requester that issued it.

---
 rtl/axi4lite_mem_arbiter_if.sv | 56 +++++
 rtl/axi4lite_mem_arbiter.sv | 112 +++++++++++
 tb/tb_axi4lite_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_mem_arbiter_if.sv
// axi4lite_mem_arbiter_if: requester-side and AXI4-Lite master-side signals of the arbiter.
// master = arbiter view, slave = requesters plus AXI slave view.
interface axi4lite_mem_arbiter_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
);
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0]                  req_we;
    logic [2*ADDR_WIDTH-1:0]     req_addr;
    logic [2*AXI_DATA_WIDTH-1:0] req_wdata;
    logic [2*STRB_WIDTH-1:0]     req_wstrb;
    logic [1:0]                  rsp_valid;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata;
    logic                        rsp_err;
    logic [ADDR_WIDTH-1:0]       maxi_araddr;
    logic [2:0]                  maxi_arprot;
    logic                        maxi_arvalid;
    logic                        maxi_arready;
    logic [AXI_DATA_WIDTH-1:0]   maxi_rdata;
    logic [1:0]                  maxi_rresp;
    logic                        maxi_rvalid;
    logic                        maxi_rready;
    logic [ADDR_WIDTH-1:0]       maxi_awaddr;
    logic [2:0]                  maxi_awprot;
    logic                        maxi_awvalid;
    logic                        maxi_awready;
    logic [AXI_DATA_WIDTH-1:0]   maxi_wdata;
    logic [STRB_WIDTH-1:0]       maxi_wstrb;
    logic                        maxi_wvalid;
    logic                        maxi_wready;
    logic                        maxi_bvalid;
    logic [1:0]                  maxi_bresp;
    logic                        maxi_bready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  maxi_arready, maxi_rdata, maxi_rresp, maxi_rvalid,
        input  maxi_awready, maxi_wready, maxi_bvalid, maxi_bresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output maxi_araddr, maxi_arprot, maxi_arvalid, maxi_rready,
        output maxi_awaddr, maxi_awprot, maxi_awvalid,
        output maxi_wdata, maxi_wstrb, maxi_wvalid, maxi_bready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output maxi_arready, maxi_rdata, maxi_rresp, maxi_rvalid,
        output maxi_awready, maxi_wready, maxi_bvalid, maxi_bresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  maxi_araddr, maxi_arprot, maxi_arvalid, maxi_rready,
        input  maxi_awaddr, maxi_awprot, maxi_awvalid,
        input  maxi_wdata, maxi_wstrb, maxi_wvalid, maxi_bready
    );
endinterface

// File: rtl/axi4lite_mem_arbiter.sv
// axi4lite_mem_arbiter: serialises two requesters onto one AXI4-Lite master, one transaction outstanding.
// Round-robin by default; define ARB_FIXED_PRIO_EN to make requester 1 win every tie.
module axi4lite_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int STRB_WIDTH     = AXI_DATA_WIDTH / 8
) (
    input logic                   axi_clk,
    input logic                   axi_rst,
    axi4lite_mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t                    state;
    logic                      last_grant, cur, grant, aw_done, w_done, aw_fire, w_fire;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;

`ifdef ARB_FIXED_PRIO_EN
    assign grant = bus.req_valid[1];
`else
    assign grant = &bus.req_valid ? ~last_grant : bus.req_valid[1];
`endif

    assign bus.req_ready   = (state == IDLE && |bus.req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign aw_fire         = bus.maxi_awvalid & bus.maxi_awready;
    assign w_fire          = bus.maxi_wvalid & bus.maxi_wready;
    assign bus.maxi_araddr = addr_q;
    assign bus.maxi_awaddr = addr_q;
    assign bus.maxi_wdata  = wdata_q;
    assign bus.maxi_wstrb  = wstrb_q;
    // requester 0 is instruction fetch
    assign bus.maxi_arprot = cur ? 3'b000 : 3'b100;
    assign bus.maxi_awprot = cur ? 3'b000 : 3'b100;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            cur              <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            bus.maxi_arvalid <= 1'b0;
            bus.maxi_rready  <= 1'b0;
            bus.maxi_awvalid <= 1'b0;
            bus.maxi_wvalid  <= 1'b0;
            bus.maxi_bready  <= 1'b0;
            bus.rsp_valid    <= '0;
            bus.rsp_rdata    <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                IDLE: if (|bus.req_valid) begin
                    last_grant <= grant;
                    cur        <= grant;
                    addr_q     <= grant ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
                    wdata_q    <= grant ? bus.req_wdata[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH] : bus.req_wdata[AXI_DATA_WIDTH-1:0];
                    wstrb_q    <= grant ? bus.req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : bus.req_wstrb[STRB_WIDTH-1:0];
                    if (bus.req_we[grant]) begin
                        state            <= WR_REQ;
                        bus.maxi_awvalid <= 1'b1;
                        bus.maxi_wvalid  <= 1'b1;
                        aw_done          <= 1'b0;
                        w_done           <= 1'b0;
                    end else begin
                        state            <= RD_ADDR;
                        bus.maxi_arvalid <= 1'b1;
                    end
                end
                RD_ADDR: if (bus.maxi_arready) begin
                    bus.maxi_arvalid <= 1'b0;
                    bus.maxi_rready  <= 1'b1;
                    state            <= RD_DATA;
                end
                RD_DATA: if (bus.maxi_rvalid) begin
                    bus.maxi_rready <= 1'b0;
                    bus.rsp_valid   <= cur ? 2'b10 : 2'b01;
                    bus.rsp_rdata   <= bus.maxi_rdata;
                    bus.rsp_err     <= |bus.maxi_rresp;
                    state           <= IDLE;
                end
                WR_REQ: begin
                    if (aw_fire) begin
                        bus.maxi_awvalid <= 1'b0;
                        aw_done          <= 1'b1;
                    end
                    if (w_fire) begin
                        bus.maxi_wvalid <= 1'b0;
                        w_done          <= 1'b1;
                    end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        bus.maxi_bready <= 1'b1;
                        state           <= WR_RESP;
                    end
                end
                WR_RESP: if (bus.maxi_bvalid) begin
                    bus.maxi_bready <= 1'b0;
                    bus.rsp_valid   <= cur ? 2'b10 : 2'b01;
                    bus.rsp_rdata   <= '0;
                    bus.rsp_err     <= |bus.maxi_bresp;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_mem_arbiter.sv
// tb_axi4lite_mem_arbiter: directed checks of arbitration, AXI handshakes, responses and reset.
module tb_axi4lite_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    axi4lite_mem_arbiter_if #(.ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) bus();

    axi4lite_mem_arbiter #(.ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
        .axi_clk(clk),
        .axi_rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        #1;
        for (int k = 0; k < 20 && bus.req_ready == 2'b00; k++) tick();
        n_cmp++; if (bus.req_ready == 2'b00) begin n_err++; $display("FAIL %s_ready_timeout got %b", name, bus.req_ready); end
    endtask

    task automatic do_read(input logic idx, input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp);
        bus.req_valid = idx ? 2'b10 : 2'b01;
        bus.req_we[idx] = 1'b0;
        if (idx) bus.req_addr[127:64] = a; else bus.req_addr[63:0] = a;
        wait_ready("rd");
        tick();
        bus.req_valid = 2'b00;
        bus.maxi_arready = 1'b1;
        tick();
        bus.maxi_arready = 1'b0;
        bus.maxi_rvalid = 1'b1;
        bus.maxi_rdata = d;
        bus.maxi_rresp = resp;
        tick();
        bus.maxi_rvalid = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic idx, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input logic [1:0] resp);
        bus.req_valid = idx ? 2'b10 : 2'b01;
        bus.req_we[idx] = 1'b1;
        if (idx) begin bus.req_addr[127:64] = a; bus.req_wdata[127:64] = d; bus.req_wstrb[15:8] = s; end
        else begin bus.req_addr[63:0] = a; bus.req_wdata[63:0] = d; bus.req_wstrb[7:0] = s; end
        wait_ready("wr");
        tick();
        bus.req_valid = 2'b00;
        bus.req_we = 2'b00;
        bus.maxi_awready = 1'b1;
        bus.maxi_wready = 1'b1;
        tick();
        bus.maxi_awready = 1'b0;
        bus.maxi_wready = 1'b0;
        bus.maxi_bvalid = 1'b1;
        bus.maxi_bresp = resp;
        tick();
        bus.maxi_bvalid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (bus.maxi_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid got %b exp 0", bus.maxi_arvalid); end
        n_cmp++; if (bus.maxi_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid got %b exp 0", bus.maxi_awvalid); end
        n_cmp++; if (bus.maxi_wvalid !== 1'b0) begin n_err++; $display("FAIL rst_wvalid got %b exp 0", bus.maxi_wvalid); end
        n_cmp++; if (bus.maxi_rready !== 1'b0) begin n_err++; $display("FAIL rst_rready got %b exp 0", bus.maxi_rready); end
        n_cmp++; if (bus.maxi_bready !== 1'b0) begin n_err++; $display("FAIL rst_bready got %b exp 0", bus.maxi_bready); end
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid got %b exp 00", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rsp_rdata got %h exp 0", bus.rsp_rdata); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err got %b exp 0", bus.rsp_err); end
        n_cmp++; if (bus.maxi_araddr !== 64'h0) begin n_err++; $display("FAIL rst_araddr got %h exp 0", bus.maxi_araddr); end
        n_cmp++; if (bus.maxi_wdata !== 64'h0) begin n_err++; $display("FAIL rst_wdata got %h exp 0", bus.maxi_wdata); end
        n_cmp++; if (bus.maxi_wstrb !== 8'h0) begin n_err++; $display("FAIL rst_wstrb got %h exp 0", bus.maxi_wstrb); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        bus.req_valid = 2'b01;
        bus.req_we = 2'b00;
        bus.req_addr[63:0] = 64'h8000_0000;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL sr_ready got %b exp 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        bus.maxi_arready = 1'b1;
        #1;
        n_cmp++; if (bus.maxi_arvalid !== 1'b1) begin n_err++; $display("FAIL sr_arvalid got %b exp 1", bus.maxi_arvalid); end
        n_cmp++; if (bus.maxi_araddr !== 64'h8000_0000) begin n_err++; $display("FAIL sr_araddr got %h exp 80000000", bus.maxi_araddr); end
        n_cmp++; if (bus.maxi_arprot !== 3'b100) begin n_err++; $display("FAIL sr_arprot got %b exp 100", bus.maxi_arprot); end
        tick();
        bus.maxi_arready = 1'b0;
        bus.maxi_rvalid = 1'b1;
        bus.maxi_rdata = 64'hDEAD_BEEF_0000_0001;
        bus.maxi_rresp = 2'b00;
        #1;
        n_cmp++; if (bus.maxi_rready !== 1'b1) begin n_err++; $display("FAIL sr_rready got %b exp 1", bus.maxi_rready); end
        n_cmp++; if (bus.maxi_arvalid !== 1'b0) begin n_err++; $display("FAIL sr_arvalid_drop got %b exp 0", bus.maxi_arvalid); end
        tick();
        bus.maxi_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL sr_rsp_valid got %b exp 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL sr_rsp_rdata got %h exp deadbeef00000001", bus.rsp_rdata); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL sr_rsp_err got %b exp 0", bus.rsp_err); end
        tick();
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL sr_rsp_pulse got %b exp 00", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL sr_rsp_hold got %h exp deadbeef00000001", bus.rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_we = 2'b00;
        bus.req_addr = {64'h200, 64'h100};
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 2'b10;
`else
            exp = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
            n_cmp++; if (bus.req_ready !== exp) begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", i, bus.req_ready, exp); end
            tick();
            bus.maxi_arready = 1'b1;
            #1;
            n_cmp++; if (bus.maxi_araddr !== (exp[1] ? 64'h200 : 64'h100)) begin n_err++; $display("FAIL rr_araddr[%0d] got %h", i, bus.maxi_araddr); end
            tick();
            bus.maxi_arready = 1'b0;
            bus.maxi_rvalid = 1'b1;
            bus.maxi_rdata = 64'(i + 16);
            bus.maxi_rresp = 2'b00;
            tick();
            bus.maxi_rvalid = 1'b0;
            #1;
            n_cmp++; if (bus.rsp_valid !== exp) begin n_err++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", i, bus.rsp_valid, exp); end
            n_cmp++; if (bus.rsp_rdata !== 64'(i + 16)) begin n_err++; $display("FAIL rr_rsp_rdata[%0d] got %h exp %h", i, bus.rsp_rdata, i + 16); end
        end
        bus.req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write_split();
        int aw_hs = 0;
        int w_hs = 0;
        bus.req_valid = 2'b10;
        bus.req_we = 2'b10;
        bus.req_addr[127:64] = 64'h1000;
        bus.req_wdata[127:64] = 64'h55;
        bus.req_wstrb[15:8] = 8'h01;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL ws_ready got %b exp 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        bus.req_we = 2'b00;
        bus.maxi_wready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) bus.maxi_awready = 1'b1;
            #1;
            n_cmp++; if (bus.maxi_awvalid !== 1'b1) begin n_err++; $display("FAIL ws_awvalid[%0d] got %b exp 1", c, bus.maxi_awvalid); end
            n_cmp++; if (bus.maxi_wvalid !== (c == 1)) begin n_err++; $display("FAIL ws_wvalid[%0d] got %b exp %b", c, bus.maxi_wvalid, c == 1); end
            n_cmp++; if (bus.maxi_bready !== 1'b0) begin n_err++; $display("FAIL ws_bready_early[%0d] got %b exp 0", c, bus.maxi_bready); end
            if (c == 1) begin
                n_cmp++; if (bus.maxi_awaddr !== 64'h1000) begin n_err++; $display("FAIL ws_awaddr got %h exp 1000", bus.maxi_awaddr); end
                n_cmp++; if (bus.maxi_wdata !== 64'h55) begin n_err++; $display("FAIL ws_wdata got %h exp 55", bus.maxi_wdata); end
                n_cmp++; if (bus.maxi_wstrb !== 8'h01) begin n_err++; $display("FAIL ws_wstrb got %h exp 01", bus.maxi_wstrb); end
                n_cmp++; if (bus.maxi_awprot !== 3'b000) begin n_err++; $display("FAIL ws_awprot got %b exp 000", bus.maxi_awprot); end
            end
            aw_hs += int'(bus.maxi_awvalid & bus.maxi_awready);
            w_hs += int'(bus.maxi_wvalid & bus.maxi_wready);
            tick();
        end
        bus.maxi_awready = 1'b0;
        bus.maxi_wready = 1'b0;
        bus.maxi_bvalid = 1'b1;
        bus.maxi_bresp = 2'b00;
        #1;
        n_cmp++; if (bus.maxi_bready !== 1'b1) begin n_err++; $display("FAIL ws_bready got %b exp 1", bus.maxi_bready); end
        n_cmp++; if (bus.maxi_awvalid !== 1'b0) begin n_err++; $display("FAIL ws_awvalid_drop got %b exp 0", bus.maxi_awvalid); end
        tick();
        bus.maxi_bvalid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 2'b10) begin n_err++; $display("FAIL ws_rsp_valid got %b exp 10", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL ws_rsp_err got %b exp 0", bus.rsp_err); end
        n_cmp++; if (aw_hs !== 1) begin n_err++; $display("FAIL ws_aw_count got %0d exp 1", aw_hs); end
        n_cmp++; if (w_hs !== 1) begin n_err++; $display("FAIL ws_w_count got %0d exp 1", w_hs); end
        tick();
    endtask

    task automatic test_error();
        do_read(1'b0, 64'h3000, 64'h1234, 2'b10);
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL er_rsp_valid got %b exp 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL er_rsp_err got %b exp 1", bus.rsp_err); end
        n_cmp++; if (bus.rsp_rdata !== 64'h1234) begin n_err++; $display("FAIL er_rsp_rdata got %h exp 1234", bus.rsp_rdata); end
        tick();
        do_write(1'b0, 64'h3008, 64'hAA, 8'hFF, 2'b00);
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL ok_rsp_valid got %b exp 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL ok_rsp_err got %b exp 0", bus.rsp_err); end
        n_cmp++; if (bus.rsp_rdata !== 64'h0) begin n_err++; $display("FAIL ok_rsp_rdata got %h exp 0", bus.rsp_rdata); end
        tick();
    endtask

    task automatic test_arready_stall();
        bus.req_valid = 2'b10;
        bus.req_we = 2'b00;
        bus.req_addr[127:64] = 64'h2468;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL st_ready got %b exp 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b11;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++; if (bus.maxi_arvalid !== 1'b1) begin n_err++; $display("FAIL st_arvalid[%0d] got %b exp 1", c, bus.maxi_arvalid); end
            n_cmp++; if (bus.maxi_araddr !== 64'h2468) begin n_err++; $display("FAIL st_araddr[%0d] got %h exp 2468", c, bus.maxi_araddr); end
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL st_req_ready[%0d] got %b exp 00", c, bus.req_ready); end
            tick();
        end
        bus.req_valid = 2'b00;
        bus.maxi_arready = 1'b1;
        tick();
        bus.maxi_arready = 1'b0;
        bus.maxi_rvalid = 1'b1;
        bus.maxi_rdata = 64'h77;
        bus.maxi_rresp = 2'b00;
        tick();
        bus.maxi_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 2'b10) begin n_err++; $display("FAIL st_rsp_valid got %b exp 10", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 64'h77) begin n_err++; $display("FAIL st_rsp_rdata got %h exp 77", bus.rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 2'b01;
        bus.req_we = 2'b00;
        bus.req_addr[63:0] = 64'h4000;
        #1;
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rm_ready got %b exp 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        bus.maxi_arready = 1'b1;
        tick();
        bus.maxi_arready = 1'b0;
        #1;
        n_cmp++; if (bus.maxi_rready !== 1'b1) begin n_err++; $display("FAIL rm_rready got %b exp 1", bus.maxi_rready); end
        rst = 1'b1;
        bus.maxi_rvalid = 1'b1;
        bus.maxi_rdata = 64'h99;
        tick();
        rst = 1'b0;
        bus.maxi_rvalid = 1'b0;
        bus.req_valid = 2'b01;
        bus.req_addr[63:0] = 64'h5000;
        #1;
        n_cmp++; if (bus.maxi_rready !== 1'b0) begin n_err++; $display("FAIL rm_rready_rst got %b exp 0", bus.maxi_rready); end
        n_cmp++; if (bus.maxi_arvalid !== 1'b0) begin n_err++; $display("FAIL rm_arvalid_rst got %b exp 0", bus.maxi_arvalid); end
        n_cmp++; if ({bus.maxi_awvalid, bus.maxi_wvalid, bus.maxi_bready} !== 3'b000) begin n_err++; $display("FAIL rm_wr_rst got %b exp 000", {bus.maxi_awvalid, bus.maxi_wvalid, bus.maxi_bready}); end
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rm_rsp_valid got %b exp 00", bus.rsp_valid); end
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rm_accept got %b exp 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        bus.maxi_arready = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rm_no_rsp got %b exp 00", bus.rsp_valid); end
        n_cmp++; if (bus.maxi_araddr !== 64'h5000) begin n_err++; $display("FAIL rm_araddr got %h exp 5000", bus.maxi_araddr); end
        tick();
        bus.maxi_arready = 1'b0;
        bus.maxi_rvalid = 1'b1;
        bus.maxi_rdata = 64'hABC;
        tick();
        bus.maxi_rvalid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 2'b01) begin n_err++; $display("FAIL rm_rsp_after got %b exp 01", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_rdata !== 64'hABC) begin n_err++; $display("FAIL rm_rdata_after got %h exp abc", bus.rsp_rdata); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.maxi_arready = 1'b0;
        bus.maxi_rdata = '0;
        bus.maxi_rresp = '0;
        bus.maxi_rvalid = 1'b0;
        bus.maxi_awready = 1'b0;
        bus.maxi_wready = 1'b0;
        bus.maxi_bvalid = 1'b0;
        bus.maxi_bresp = '0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_split();
        test_error();
        test_arready_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
